// File: rtl/rca_pkg.sv
// Shared types and helpers for the sequential wide adder and its chunk datapath.
// Holds the FSM state encoding, default widths and the chunk-index width function.
// No logic or timing of its own.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W = 16;
    localparam int DEF_N = 4;

    // A single-chunk add still needs a one-bit index register.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/rca_chunk_cin.sv
// N-bit ripple-carry adder with carry-in, one full-adder cell per bit.
// Purely combinational, zero cycles.
// No handshake.
module rca_chunk_cin #(
    parameter int N = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < N; i++) begin : g_bit
        rca_fa u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (carry[i]),
            .s_o (sum_o[i]),
            .c_o (carry[i+1])
        );
    end

    assign cout_o = carry[N];

endmodule

// File: rtl/rca_fa.sv
// One-bit full adder cell.
// Purely combinational, zero cycles.
// No handshake.
module rca_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_seq_wide_adder.sv
// W-bit adder built from one N-bit ripple stage, one chunk per cycle LSB first.
// Latency: out_valid rises W/N edges after the accept edge.
// Backpressure: result held in DONE until out_ready; accepts only in IDLE.
module rca_seq_wide_adder
    import rca_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum,
    output logic         busy
);

    localparam int CHUNKS = W / N;
    localparam int IW     = idx_width(CHUNKS);

    if (N < 1 || W < N || (W % N) != 0) begin : g_bad_params
        $error("rca_seq_wide_adder: W must be a positive multiple of N");
    end

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W:0]      sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;

    logic [N-1:0]    chunk_a, chunk_b, chunk_s;
    logic            chunk_c;
    logic            last_chunk;

    assign chunk_a    = a_q[idx_q*N +: N];
    assign chunk_b    = b_q[idx_q*N +: N];
    assign last_chunk = (idx_q == IW'(CHUNKS - 1));

    rca_chunk_cin #(.N(N)) u_chunk (
        .a_i    (chunk_a),
        .b_i    (chunk_b),
        .cin_i  (carry_q),
        .sum_o  (chunk_s),
        .cout_o (chunk_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Operands are captured only on the IDLE accept, so input churn during RUN is harmless.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            end
            RUN: begin
                sum_d[idx_q*N +: N] = chunk_s;
                carry_d             = chunk_c;
                idx_d               = idx_q + 1'b1;
                if (last_chunk) begin
                    sum_d[W] = chunk_c;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
        end
    end

    assign out_sum = sum_q;

endmodule

// File: tb/tb_rca_seq_wide_adder.sv
// Bench for rca_seq_wide_adder across four (W,N) builds against an arithmetic reference.
// Directed cases run on the (16,4) build; random sweeps run on every build.
module tb_rca_seq_wide_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ia, ib;
    logic        ordy;
    logic        iv  [4];
    logic        ir  [4];
    logic        ov  [4];
    logic        bsy [4];
    logic [16:0] s0;
    logic [8:0]  s1;
    logic [12:0] s2;
    logic [32:0] s3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rca_seq_wide_adder #(.W(16), .N(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[15:0]), .in_b(ib[15:0]), .out_valid(ov[0]), .out_ready(ordy),
        .out_sum(s0), .busy(bsy[0])
    );
    rca_seq_wide_adder #(.W(8), .N(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[7:0]), .in_b(ib[7:0]), .out_valid(ov[1]), .out_ready(ordy),
        .out_sum(s1), .busy(bsy[1])
    );
    rca_seq_wide_adder #(.W(12), .N(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[11:0]), .in_b(ib[11:0]), .out_valid(ov[2]), .out_ready(ordy),
        .out_sum(s2), .busy(bsy[2])
    );
    rca_seq_wide_adder #(.W(32), .N(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_a(ia), .in_b(ib), .out_valid(ov[3]), .out_ready(ordy),
        .out_sum(s3), .busy(bsy[3])
    );

    function automatic logic [32:0] get_sum(input int k);
        case (k)
            0:       return 33'(s0);
            1:       return 33'(s1);
            2:       return 33'(s2);
            default: return s3;
        endcase
    endfunction

    function automatic int width_of(input int k);
        case (k)
            0:       return 16;
            1:       return 8;
            2:       return 12;
            default: return 32;
        endcase
    endfunction

    function automatic int chunks_of(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            2:       return 4;
            default: return 32;
        endcase
    endfunction

    // Reference: plain unsigned addition of the operands truncated to W bits.
    function automatic logic [32:0] ref_sum(input int w, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m;
        logic [63:0] r;
        m = (64'd1 << w) - 64'd1;
        r = ({32'd0, a} & m) + ({32'd0, b} & m);
        return r[32:0];
    endfunction

    // Drives one transaction; returns sum seen at the output handshake and edges from accept to out_valid.
    task automatic run_add(input int k, input logic [31:0] a, input logic [31:0] b, input int stall,
                           output logic [32:0] sum, output int lat, output bit to);
        int t;
        to  = 1'b0;
        lat = 0;
        sum = '0;
        @(negedge clk);
        ia = a; ib = b; iv[k] = 1'b1; ordy = 1'b0;
        t = 0;
        while (!ir[k] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ir[k]) begin
            iv[k] = 1'b0;
            to = 1'b1;
            return;
        end
        @(negedge clk);
        iv[k] = 1'b0;
        while (!ov[k] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!ov[k]) begin
            to = 1'b1;
            return;
        end
        repeat (stall) @(negedge clk);
        sum  = get_sum(k);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (ir[0] !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready got=%b want=1", ir[0]); end
        n_cmp++; if (ov[0] !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid got=%b want=0", ov[0]); end
        n_cmp++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", bsy[0]); end
        n_cmp++; if (s0 !== 17'h0)    begin n_err++; $display("FAIL reset_out_sum got=%h want=0", s0); end
    endtask

    task automatic test_basic();
        logic [32:0] s;
        int lat;
        bit to;
        run_add(0, 32'h1234, 32'h4321, 0, s, lat, to);
        n_cmp++; if (to)             begin n_err++; $display("FAIL basic_timeout got=timeout want=done"); end
        n_cmp++; if (s !== 33'h05555) begin n_err++; $display("FAIL basic_sum got=%h want=05555", s); end
        n_cmp++; if (lat !== 4)      begin n_err++; $display("FAIL basic_latency got=%0d want=4", lat); end
        n_cmp++; if (ir[0] !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after got=%b want=1", ir[0]); end
    endtask

    task automatic test_carry();
        logic [32:0] s;
        int lat;
        bit to;
        run_add(0, 32'hFFFF, 32'h0001, 1, s, lat, to);
        n_cmp++; if (to || s !== 33'h10000) begin n_err++; $display("FAIL carry_ripple got=%h want=10000", s); end
        run_add(0, 32'hFFFF, 32'hFFFF, 0, s, lat, to);
        n_cmp++; if (to || s !== 33'h1FFFE) begin n_err++; $display("FAIL carry_max got=%h want=1fffe", s); end
    endtask

    task automatic test_backpressure();
        int t;
        @(negedge clk);
        ia = 32'h0A0B; ib = 32'h0102; iv[0] = 1'b1; ordy = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        t = 0;
        while (!ov[0] && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (ov[0] !== 1'b1) begin n_err++; $display("FAIL bp_reach_done got=%b want=1", ov[0]); end
        ia = 32'h7777; ib = 32'h1111; iv[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (ov[0] !== 1'b1 || s0 !== 17'h0B0D || ir[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc=%0d got ov=%b sum=%h rdy=%b want ov=1 sum=0b0d rdy=0", c, ov[0], s0, ir[0]);
            end
            @(negedge clk);
        end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        n_cmp++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release got ov=%b rdy=%b busy=%b want ov=0 rdy=1 busy=0", ov[0], ir[0], bsy[0]);
        end
        iv[0] = 1'b0;
    endtask

    task automatic test_run_change();
        int t;
        @(negedge clk);
        ia = 32'h00AA; ib = 32'h0055; iv[0] = 1'b1; ordy = 1'b0;
        @(negedge clk);
        iv[0] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            ia = $urandom; ib = $urandom; iv[0] = 1'b1;
            @(negedge clk);
            iv[0] = 1'b0;
        end
        t = 0;
        while (!ov[0] && t < 50) begin @(negedge clk); t++; end
        n_cmp++; if (s0 !== 17'h000FF) begin n_err++; $display("FAIL run_change_sum got=%h want=000ff", s0); end
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        @(negedge clk);
        n_cmp++; if (bsy[0] !== 1'b0) begin n_err++; $display("FAIL run_change_no_second got busy=%b want=0", bsy[0]); end
    endtask

    task automatic test_reset_mid();
        logic [32:0] s;
        int lat;
        bit to;
        bit seen;
        @(negedge clk);
        ia = 32'h0F0F; ib = 32'h0101; iv[0] = 1'b1; ordy = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_cmp++; if (bsy[0] !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before got=%b want=1", bsy[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bsy[0] !== 1'b0 || s0 !== 17'h0) begin
            n_err++;
            $display("FAIL midrst_values got rdy=%b ov=%b busy=%b sum=%h want 1 0 0 0", ir[0], ov[0], bsy[0], s0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        ordy = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_valid got=%b want=0", seen); end
        run_add(0, 32'h0001, 32'h0002, 0, s, lat, to);
        n_cmp++; if (to || s !== 33'h00003) begin n_err++; $display("FAIL midrst_next_add got=%h want=00003", s); end
    endtask

    task automatic test_sweep();
        logic [32:0] s, e;
        logic [31:0] a, b;
        int lat;
        bit to;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 500; i++) begin
                a = $urandom;
                b = $urandom;
                if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; end
                e = ref_sum(width_of(k), a, b);
                run_add(k, a, b, $urandom_range(0, 3), s, lat, to);
                n_cmp++;
                if (to || s !== e) begin
                    n_err++;
                    $display("FAIL sweep_sum w=%0d a=%h b=%h got=%h want=%h", width_of(k), a, b, s, e);
                end
                n_cmp++;
                if (lat !== chunks_of(k)) begin
                    n_err++;
                    $display("FAIL sweep_latency w=%0d got=%0d want=%0d", width_of(k), lat, chunks_of(k));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ia    = '0;
        ib    = '0;
        ordy  = 1'b0;
        for (int k = 0; k < 4; k++) iv[k] = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_carry();
        test_backpressure();
        test_run_change();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
